// File: rtl/sd_init_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_init_seq_pkg
// Description : Shared constants and types for the SD-card SPI-mode init
//               sequencer. Holds the command indices, the R1 response codes,
//               the 3-bit step encoding reported on err_step, and the
//               sequencer state type.
//               Also intended for SDdriver status decode.
// Options     : SD_INIT_SEQ_CMD16_EN - adds the CMD16 state.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_init_seq_pkg;

  // Command indices driven on sd_cmd
  localparam logic [6:0] CMD0  = 7'd0;
  localparam logic [6:0] CMD8  = 7'd8;
  localparam logic [6:0] CMD16 = 7'd16;
  localparam logic [6:0] CMD55 = 7'd55;
  localparam logic [6:0] CMD41 = 7'd41;

  // R1 response codes
  localparam logic [6:0] R1_IDLE    = 7'h01;
  localparam logic [6:0] R1_READY   = 7'h00;
  localparam logic [6:0] R1_ILLEGAL = 7'h05;

  // Step encoding reported on err_step
  typedef enum logic [2:0] {
    STEP_NONE  = 3'd0,
    STEP_CMD0  = 3'd1,
    STEP_CMD8  = 3'd2,
    STEP_CMD55 = 3'd3,
    STEP_CMD41 = 3'd4,
    STEP_CMD16 = 3'd5
  } step_e;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_POWERUP = 4'd1,
    S_CMD0    = 4'd2,
    S_CMD8    = 4'd3,
    S_CMD55   = 4'd4,
    S_CMD41   = 4'd5,
`ifdef SD_INIT_SEQ_CMD16_EN
    S_CMD16   = 4'd6,
`endif
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_e;

  // Command index issued by a command state
  function automatic logic [6:0] cmd_index(input state_e s);
    logic [6:0] idx;
    idx = CMD0;
    case (s)
      S_CMD8:  idx = CMD8;
      S_CMD55: idx = CMD55;
      S_CMD41: idx = CMD41;
`ifdef SD_INIT_SEQ_CMD16_EN
      S_CMD16: idx = CMD16;
`endif
      default: idx = CMD0;
    endcase
    return idx;
  endfunction

  // Step code reported when a state fails
  function automatic step_e step_of(input state_e s);
    step_e st;
    st = STEP_NONE;
    case (s)
      S_CMD0:  st = STEP_CMD0;
      S_CMD8:  st = STEP_CMD8;
      S_CMD55: st = STEP_CMD55;
      S_CMD41: st = STEP_CMD41;
`ifdef SD_INIT_SEQ_CMD16_EN
      S_CMD16: st = STEP_CMD16;
`endif
      default: st = STEP_NONE;
    endcase
    return st;
  endfunction

  // True for states that run the ISSUE/WAIT handshake
  function automatic logic is_cmd_state(input state_e s);
    logic r;
    r = 1'b0;
    case (s)
      S_CMD0, S_CMD8, S_CMD55, S_CMD41: r = 1'b1;
`ifdef SD_INIT_SEQ_CMD16_EN
      S_CMD16: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_init_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_init_seq_if
// Description : Command bus between the init sequencer and SDctrl.
//   sd_cmd          7  command index
//   sd_en           1  one-cycle command issue pulse
//   sd_en_clk       1  SCK enable
//   sd_div_clk      8  SCK divider
//   sd_cs           1  chip select, 1 = deselected
//   sd_rdy          1  SDctrl ready
//   sd_valid_status 1  one-cycle pulse, sd_resp_status valid
//   sd_resp_status  7  R1 response bits [6:0]
//   master = sequencer side, slave = SDctrl side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_init_seq_if;
  logic [6:0] sd_cmd;
  logic       sd_en;
  logic       sd_en_clk;
  logic [7:0] sd_div_clk;
  logic       sd_cs;
  logic       sd_rdy;
  logic       sd_valid_status;
  logic [6:0] sd_resp_status;

  modport master (
    output sd_cmd, sd_en, sd_en_clk, sd_div_clk, sd_cs,
    input  sd_rdy, sd_valid_status, sd_resp_status
  );

  modport slave (
    input  sd_cmd, sd_en, sd_en_clk, sd_div_clk, sd_cs,
    output sd_rdy, sd_valid_status, sd_resp_status
  );
endinterface
`default_nettype wire

// File: rtl/sd_init_seq_cmd_issue.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_issue
// Description : ISSUE/WAIT handshake shared by every command state.
//               In ISSUE, the first cycle with rdy=1 while active fires a
//               one-cycle en pulse and enters WAIT. In WAIT, a valid pulse
//               or a timeout returns to ISSUE.
//   clk, rst_n    clock, asynchronous active-low reset
//   active        sequencer is in a command state
//   rdy           SDctrl ready
//   valid         response valid pulse
//   en            registered command issue pulse
//   resp_fire     valid seen while waiting (comb)
//   timeout_fire  timeout expiry while waiting, no response (comb)
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_issue #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  active,
  input  wire  rdy,
  input  wire  valid,
  output logic en,
  output logic resp_fire,
  output logic timeout_fire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          r_waiting;
  logic [TW-1:0] r_tmo_cnt;

  assign resp_fire = r_waiting & valid;
  // Counter is 0 in the cycle en is high, so it reads TIMEOUT_CYCLES-1 at
  // the edge that lands exactly TIMEOUT_CYCLES cycles after the pulse.
  // A coincident response takes priority.
  assign timeout_fire = r_waiting & ~valid &
                        (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waiting <= 1'b0;
      r_tmo_cnt <= '0;
      en        <= 1'b0;
    end else begin
      en <= 1'b0;
      if (!r_waiting) begin
        if (active && rdy) begin
          en        <= 1'b1;
          r_waiting <= 1'b1;
          r_tmo_cnt <= '0;
        end
      end else if (resp_fire || timeout_fire) begin
        r_waiting <= 1'b0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : sd_init_seq
// Description : SD-card SPI-mode init sequencer. Powers up SCK with CS high,
//               then runs CMD0, CMD8, CMD55/ACMD41 (and optionally CMD16)
//               through SDctrl and switches SCK to the fast divider.
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse, accepted in IDLE, DONE or ERR
//   bus       SDctrl command bus (sd_init_seq_if.master)
//   done      card initialised
//   err       initialisation failed
//   err_step  failing step (valid while err=1)
//   v1_card   CMD8 answered illegal-command
// Options     : SD_INIT_SEQ_CMD16_EN - issue CMD16 after ACMD41 success;
//               undefined, ACMD41 success goes straight to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_init_seq #(
  parameter int         POWERUP_CYCLES = 33280,
  parameter logic [7:0] DIV_SLOW       = 8'hD0,
  parameter logic [7:0] DIV_FAST       = 8'h02,
  parameter int         RETRY_MAX      = 255,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  wire            clk,
  input  wire            rst_n,
  input  wire            start,
  sd_init_seq_if.master  bus,
  output logic           done,
  output logic           err,
  output logic [2:0]     err_step,
  output logic           v1_card
);

  import sd_init_seq_pkg::*;

  localparam int PW = $clog2(POWERUP_CYCLES + 1);

  state_e        r_state;
  logic [PW-1:0] r_pwr_cnt;
  logic [7:0]    r_retry;
  logic [6:0]    r_cmd;
  logic          r_en_clk;
  logic [7:0]    r_div;
  logic          r_cs;
  logic          r_done;
  logic          r_err;
  logic [2:0]    r_err_step;
  logic          r_v1;

  logic   w_active;
  logic   w_en;
  logic   w_resp;
  logic   w_timeout;
  logic   w_retry_full;
  state_e w_next;
  logic   w_fail;
  logic   w_retry_inc;
  logic   w_retry_clr;
  logic   w_v1_load;
  logic   w_v1_val;
  logic [6:0] w_status;

  assign w_active     = is_cmd_state(r_state);
  assign w_status     = bus.sd_resp_status;
  assign w_retry_full = (r_retry == 8'(RETRY_MAX));

  sd_cmd_issue #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_issue (
    .clk          (clk),
    .rst_n        (rst_n),
    .active       (w_active),
    .rdy          (bus.sd_rdy),
    .valid        (bus.sd_valid_status),
    .en           (w_en),
    .resp_fire    (w_resp),
    .timeout_fire (w_timeout)
  );

  // Response decode: where a sampled R1 leads from the current step
  always_comb begin
    w_next      = r_state;
    w_fail      = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_v1_load   = 1'b0;
    w_v1_val    = 1'b0;
    if (w_resp) begin
      case (r_state)
        S_CMD0: begin
          if (w_status == R1_IDLE) begin
            w_next = S_CMD8;
          end else if (w_retry_full) begin
            w_fail = 1'b1;
          end else begin
            w_next      = S_CMD0;
            w_retry_inc = 1'b1;
          end
        end
        S_CMD8: begin
          if (w_status == R1_IDLE || w_status == R1_ILLEGAL) begin
            w_next      = S_CMD55;
            w_retry_clr = 1'b1;
            w_v1_load   = 1'b1;
            w_v1_val    = (w_status == R1_ILLEGAL);
          end else begin
            w_fail = 1'b1;
          end
        end
        S_CMD55: begin
          if (w_status == R1_IDLE || w_status == R1_READY) w_next = S_CMD41;
          else                                              w_fail = 1'b1;
        end
        S_CMD41: begin
          if (w_status == R1_READY) begin
`ifdef SD_INIT_SEQ_CMD16_EN
            w_next = S_CMD16;
`else
            w_next = S_DONE;
`endif
          end else if (w_status == R1_IDLE) begin
            if (w_retry_full) begin
              w_fail = 1'b1;
            end else begin
              w_next      = S_CMD55;
              w_retry_inc = 1'b1;
            end
          end else begin
            w_fail = 1'b1;
          end
        end
`ifdef SD_INIT_SEQ_CMD16_EN
        S_CMD16: begin
          if (w_status == R1_READY) w_next = S_DONE;
          else                      w_fail = 1'b1;
        end
`endif
        default: ;
      endcase
    end else if (w_timeout) begin
      w_fail = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pwr_cnt  <= '0;
      r_retry    <= '0;
      r_cmd      <= CMD0;
      r_en_clk   <= 1'b0;
      r_div      <= DIV_SLOW;
      r_cs       <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_step <= STEP_NONE;
      r_v1       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_POWERUP;
            // POWERUP lasts count+1 cycles, hence the -1
            r_pwr_cnt  <= PW'(POWERUP_CYCLES - 1);
            r_en_clk   <= 1'b1;
            r_div      <= DIV_SLOW;
            r_cs       <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_step <= STEP_NONE;
            r_v1       <= 1'b0;
          end
        end
        S_POWERUP: begin
          if (r_pwr_cnt == '0) begin
            r_state <= S_CMD0;
            r_cmd   <= CMD0;
            r_cs    <= 1'b0;
            r_retry <= '0;
          end else begin
            r_pwr_cnt <= r_pwr_cnt - 1'b1;
          end
        end
        default: begin
          if (w_fail) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_step <= step_of(r_state);
            r_cs       <= 1'b1;
            r_en_clk   <= 1'b0;
          end else if (w_resp) begin
            r_state <= w_next;
            if (w_next == S_DONE) begin
              r_done <= 1'b1;
              r_div  <= DIV_FAST;
              r_cs   <= 1'b0;
            end else begin
              r_cmd <= cmd_index(w_next);
            end
            if (w_retry_clr)      r_retry <= '0;
            else if (w_retry_inc) r_retry <= r_retry + 8'd1;
            if (w_v1_load)        r_v1    <= w_v1_val;
          end
        end
      endcase
    end
  end

  assign bus.sd_cmd     = r_cmd;
  assign bus.sd_en      = w_en;
  assign bus.sd_en_clk  = r_en_clk;
  assign bus.sd_div_clk = r_div;
  assign bus.sd_cs      = r_cs;
  assign done           = r_done;
  assign err            = r_err;
  assign err_step       = r_err_step;
  assign v1_card        = r_v1;

endmodule
`default_nettype wire
